alu_pkt_ctrl: RTL and testbench

Packet sequencer between the UART receiver/transmitter and the arithmetic datapath of the UART-ALU design. It consumes received bytes, parses a 4-byte header (opcode, reserved, 16-bit length), and executes the command:
- ECHO: forward the payload back to the transmitter.
- ADD32: accumulate little-endian 32-bit operands and transmit the 4-byte sum.

Both byte streams use valid/ready handshakes, so this block alone decides when the UART TX path is used.

---
 rtl/alu_pkt_pkg.sv | 35 +++
 rtl/alu_pkt_hdr_parser.sv | 63 ++++++
 rtl/alu_pkt_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_alu_pkt_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkt_pkg.sv
// Shared types and constants for the UART-ALU packet controller.
// Header layout, opcodes and FSM state encoding.
package alu_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RSVD,
        LEN_LO,
        LEN_HI,
        ECHO,
        ACC,
        RESP,
        DROP
    } state_t;

    localparam int HDR_LEN        = 4;
    localparam int HDR_OFS_OP     = 0;
    localparam int HDR_OFS_RSVD   = 1;
    localparam int HDR_OFS_LEN_LO = 2;
    localparam int HDR_OFS_LEN_HI = 3;

    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD32 = 8'hAD;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] rem;
    } hdr_t;

    // Payload bytes after the header; short lengths mean no payload.
    function automatic logic [15:0] payload_len(input logic [15:0] len);
        return (len <= 16'(HDR_LEN)) ? 16'd0 : len - 16'(HDR_LEN);
    endfunction

endpackage

// File: rtl/alu_pkt_hdr_parser.sv
// Header parser: walks IDLE..LEN_HI, latches opcode and length.
// Emits hdr_done with the decoded header on the LEN_HI byte.
module alu_pkt_hdr_parser
    import alu_pkt_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  state_t     state_i,
    input  logic       rx_fire_i,
    input  logic [7:0] rx_data_i,
    output state_t     hdr_nxt_o,
    output logic       hdr_done_o,
    output hdr_t       hdr_o
);

    logic [7:0] op_q;
    logic [7:0] len_lo_q;
    logic [1:0] pos;
    logic       in_hdr;

    // Map header states onto their byte offset within the header.
    always_comb begin
        pos    = 2'(HDR_OFS_LEN_HI);
        in_hdr = 1'b1;
        unique case (state_i)
            IDLE:    pos = 2'(HDR_OFS_OP);
            RSVD:    pos = 2'(HDR_OFS_RSVD);
            LEN_LO:  pos = 2'(HDR_OFS_LEN_LO);
            LEN_HI:  pos = 2'(HDR_OFS_LEN_HI);
            default: in_hdr = 1'b0;
        endcase
    end

    // Advance to the next header state; LEN_HI exit is owned by the top.
    always_comb begin
        hdr_nxt_o = state_i;
        unique case (state_i)
            IDLE:    hdr_nxt_o = RSVD;
            RSVD:    hdr_nxt_o = LEN_LO;
            LEN_LO:  hdr_nxt_o = LEN_HI;
            default: hdr_nxt_o = state_i;
        endcase
    end

    // Latch opcode and low length byte as they arrive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= 8'h00;
            len_lo_q <= 8'h00;
        end else if (in_hdr && rx_fire_i) begin
            if (pos == 2'(HDR_OFS_OP))
                op_q <= rx_data_i;
            if (pos == 2'(HDR_OFS_LEN_LO))
                len_lo_q <= rx_data_i;
        end
    end

    assign hdr_done_o = in_hdr && rx_fire_i &&
                        (pos == 2'(HDR_OFS_LEN_HI));
    assign hdr_o.op   = op_q;
    assign hdr_o.rem  = payload_len({rx_data_i, len_lo_q});

endmodule

// File: rtl/alu_pkt_ctrl.sv
// Packet sequencer between UART RX/TX and the ALU datapath.
// Executes ECHO and ADD32 commands; unknown opcodes are dropped.
module alu_pkt_ctrl
    import alu_pkt_pkg::*;
#(
    parameter logic [7:0] OP_ECHO  = alu_pkt_pkg::OP_ECHO,
    parameter logic [7:0] OP_ADD32 = alu_pkt_pkg::OP_ADD32,
    parameter int         ACC_W    = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       pkt_done_o,
    output logic       bad_op_o
);

    localparam int NB = ACC_W / 8;

    state_t             state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [15:0]        rem_q, rem_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [31:0]        word_q, word_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               bad_q, bad_d;

    logic               rx_fire;
    logic               tx_fire;
    logic               hdr_done;
    hdr_t               hdr;
    state_t             hdr_nxt;
    logic               is_echo;
    logic               is_add;
    logic [31:0]        word_nxt;
    logic [7:0]         cnt_sel;
    logic [7:0]         resp_byte;
    logic               last_resp;

    alu_pkt_hdr_parser u_hdr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .state_i    (state_q),
        .rx_fire_i  (rx_fire),
        .rx_data_i  (rx_data_i),
        .hdr_nxt_o  (hdr_nxt),
        .hdr_done_o (hdr_done),
        .hdr_o      (hdr)
    );

    // Echo stops taking bytes once its payload is exhausted.
    always_comb begin
        rx_ready_o = 1'b1;
        unique case (state_q)
            ECHO:    rx_ready_o = (rem_q != 16'd0) &&
                                  (!tx_valid_q || tx_ready_i);
            RESP:    rx_ready_o = 1'b0;
            default: rx_ready_o = 1'b1;
        endcase
    end

    assign rx_fire   = rx_valid_i && rx_ready_o;
    assign tx_fire   = tx_valid_q && tx_ready_i;
    assign is_echo   = (hdr.op == OP_ECHO);
    assign is_add    = (hdr.op == OP_ADD32);
    assign word_nxt  = word_q | (32'(rx_data_i) << {idx_q, 3'b000});
    assign last_resp = (cnt_q == 8'(NB - 1));
    assign cnt_sel   = tx_fire ? cnt_q + 8'd1 : cnt_q;
    assign resp_byte = 8'(acc_q >> {cnt_sel, 3'b000});

    // Next-state and datapath updates for the packet FSM.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        word_d     = word_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        bad_d      = 1'b0;
        unique case (state_q)
            IDLE, RSVD, LEN_LO: begin
                if (rx_fire)
                    state_d = hdr_nxt;
            end
            LEN_HI: begin
                if (hdr_done) begin
                    rem_d = hdr.rem;
                    unique case (1'b1)
                        is_echo: begin
                            if (hdr.rem == 16'd0) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                state_d = ECHO;
                            end
                        end
                        is_add: begin
                            state_d = (hdr.rem == 16'd0) ? RESP : ACC;
                        end
                        default: begin
                            bad_d   = 1'b1;
                            state_d = (hdr.rem == 16'd0) ? IDLE : DROP;
                        end
                    endcase
                end
            end
            ECHO: begin
                if (rx_fire) begin
                    tx_data_d  = rx_data_i;
                    tx_valid_d = 1'b1;
                    rem_d      = rem_q - 16'd1;
                end else if (tx_fire) begin
                    tx_valid_d = 1'b0;
                end
                if (rem_q == 16'd0 && (!tx_valid_q || tx_ready_i)) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            ACC: begin
                if (rx_fire) begin
                    rem_d = rem_q - 16'd1;
                    if (idx_q == 2'd3 || rem_q == 16'd1) begin
                        acc_d  = acc_q + ACC_W'(word_nxt);
                        word_d = 32'd0;
                        idx_d  = 2'd0;
                    end else begin
                        word_d = word_nxt;
                        idx_d  = idx_q + 2'd1;
                    end
                    if (rem_q == 16'd1)
                        state_d = RESP;
                end
            end
            RESP: begin
                if (!tx_valid_q) begin
                    tx_data_d  = resp_byte;
                    tx_valid_d = 1'b1;
                end else if (tx_fire) begin
                    if (last_resp) begin
                        tx_valid_d = 1'b0;
                        cnt_d      = 8'd0;
                        acc_d      = '0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cnt_d     = cnt_q + 8'd1;
                        tx_data_d = resp_byte;
                    end
                end
            end
            DROP: begin
                if (rx_fire) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any pending TX byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            rem_q      <= 16'd0;
            acc_q      <= '0;
            word_q     <= 32'd0;
            idx_q      <= 2'd0;
            cnt_q      <= 8'd0;
            done_q     <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            bad_q      <= bad_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign busy_o     = (state_q != IDLE);
    assign pkt_done_o = done_q;
    assign bad_op_o   = bad_q;

endmodule

// File: tb/tb_alu_pkt_ctrl.sv
// Scoreboard bench for alu_pkt_ctrl: directed packets in,
// monitor pops expected TX bytes and counts status pulses.
module tb_alu_pkt_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_valid_i = 1'b0;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       pkt_done_o;
    logic       bad_op_o;

    logic       bp_en = 1'b0;
    logic       bp_val = 1'b1;
    logic       tx_cmd = 1'b1;
    int         bp_cnt = 0;

    logic [7:0] exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         pops = 0;
    int         done_cnt = 0;
    int         bad_cnt = 0;
    logic       saw_bp = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    alu_pkt_ctrl dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .busy_o     (busy_o),
        .pkt_done_o (pkt_done_o),
        .bad_op_o   (bad_op_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb tx_ready_i = bp_en ? bp_val : tx_cmd;

    // TX ready toggles every 3 cycles during the back-pressure test.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (bp_en) begin
            bp_cnt++;
            if (bp_cnt == 3) begin
                bp_cnt = 0;
                bp_val = ~bp_val;
            end
        end
    end

    // Monitor: pop and compare on every TX handshake; count pulses.
    initial forever begin
        @(negedge clk_i);
        if (rst_ni) begin
            if (prev_stall) begin
                checks++;
                if (!tx_valid_o || tx_data_o !== prev_data) begin
                    failures++;
                    $display("FAIL tx_hold: got v=%0b d=%02h want v=1 d=%02h",
                             tx_valid_o, tx_data_o, prev_data);
                end
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data  = tx_data_o;
            if (bp_en && tx_valid_o && !tx_ready_i && !rx_ready_o)
                saw_bp = 1'b1;
            if (tx_valid_o && tx_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_byte: got %02h want none", tx_data_o);
                end else begin
                    if (tx_data_o !== exp_q[0]) begin
                        failures++;
                        $display("FAIL tx_byte: got %02h want %02h",
                                 tx_data_o, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
            if (pkt_done_o) done_cnt++;
            if (bad_op_o)   bad_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got;
        got = 1'b0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk_i);
            got = rx_ready_o;
            @(posedge clk_i);
            #1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL rx_accept: got timeout want accept of %02h", b);
        end
    endtask

    task automatic send_pkt(input int n, input logic [95:0] v);
        for (int i = 0; i < n; i++)
            send_byte(v[8*(n-1-i) +: 8]);
        rx_valid_i = 1'b0;
    endtask

    task automatic expect_bytes(input int n, input logic [95:0] v);
        for (int i = 0; i < n; i++)
            exp_q.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && !busy_o && !tx_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        chk({name, "_idle"}, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        logic ok;
        #12;
        chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        chk("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("rst_tx_data",  {24'd0, tx_data_o},  32'd0);
        chk("rst_busy",     {31'd0, busy_o},     32'd0);
        chk("rst_done",     {31'd0, pkt_done_o}, 32'd0);
        chk("rst_bad",      {31'd0, bad_op_o},   32'd0);
        #10;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        expect_bytes(3, 96'h41_42_43);
        send_pkt(7, 96'hEC_00_07_00_41_42_43);
        wait_idle("echo");
        chk("echo_done", done_cnt, 1);
        chk("echo_busy", {31'd0, busy_o}, 32'd0);

        expect_bytes(4, 96'h01_00_00_00);
        send_pkt(12, 96'hAD_00_0C_00_FF_FF_FF_FF_02_00_00_00);
        wait_idle("add_wrap");
        chk("add_wrap_done", done_cnt, 2);

        expect_bytes(4, 96'h34_12_00_00);
        send_pkt(6, 96'hAD_00_06_00_34_12);
        wait_idle("add_part");
        chk("add_part_done", done_cnt, 3);

        bp_cnt = 0;
        bp_val = 1'b1;
        bp_en  = 1'b1;
        expect_bytes(5, 96'h11_22_33_44_55);
        send_pkt(9, 96'hEC_00_09_00_11_22_33_44_55);
        wait_idle("bp");
        bp_en = 1'b0;
        chk("bp_done", done_cnt, 4);
        chk("bp_rx_stall", {31'd0, saw_bp}, 32'd1);

        expect_bytes(1, 96'h99);
        send_pkt(6, 96'h77_00_06_00_AA_BB);
        send_pkt(5, 96'hEC_00_05_00_99);
        wait_idle("badop");
        chk("badop_pulses", bad_cnt, 1);
        chk("badop_done", done_cnt, 5);

        tx_cmd = 1'b1;
        expect_bytes(2, 96'h01_02);
        send_pkt(8, 96'hAD_00_08_00_01_02_03_04);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_two_bytes", {31'd0, ok}, 32'd1);
        tx_cmd = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        #19;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        tx_cmd = 1'b1;
        expect_bytes(4, 96'h00_00_00_00);
        send_pkt(4, 96'hAD_00_04_00);
        wait_idle("post_rst");
        chk("post_rst_done", done_cnt, 6);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
